// File: rtl/mp_pkg.sv
`default_nettype none
// ============================================================================
// Module : mp_pkg
// Brief  : Shared microprocessor definitions: opcodes, instruction field
//          offsets, bubble word, issue-unit state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package mp_pkg;

  // Opcodes recognised by the execute stage
  localparam logic [5:0] OP_LOAD  = 6'd2;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_ADD   = 6'd6;
  localparam logic [5:0] OP_OR    = 6'd8;
  localparam logic [5:0] OP_XOR   = 6'd9;

  // Instruction field layout
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 5;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 11;
  localparam int RD_LSB  = 16;
  localparam int REG_W   = 5;

  // Opcode 0 is not a valid operation, so this word never writes the reg file
  localparam logic [31:0] MP_NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } iiu_state_t;

  // True for opcodes the execute stage implements
  function automatic logic is_valid_opcode(input logic [5:0] op);
    case (op)
      6'd2, 6'd3, 6'd6, 6'd8, 6'd9, 6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd15: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/iiu_prog_mem.sv
`default_nettype none
// ============================================================================
// Module : iiu_prog_mem
// Brief  : DEPTH x 32 program store, synchronous write, asynchronous read.
//          Contents are deliberately not reset so a loaded program survives
//          a processor reset.
// Rev    : 1.0  initial release
// ============================================================================
module iiu_prog_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] r_mem [DEPTH];

  // Write port: one word per cycle when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_issue_unit
// Brief  : Program-store sequencer feeding the processor instruction input.
//          Issues one word, then ISSUE_GAP NOP bubbles, until prog_len words
//          have gone out, then pulses done.
//          Optional macro IIU_OPCODE_CHECK_EN: replace invalid-opcode words by
//          NOP and count them on bad_op_cnt.
// Rev    : 1.0  initial release
// ============================================================================
module instr_issue_unit
  import mp_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter int          ISSUE_GAP = 2,
  parameter logic [31:0] NOP_WORD  = MP_NOP_WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic                     stall,
  output logic [31:0]              instruction,
  output logic                     issue,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done
`ifdef IIU_OPCODE_CHECK_EN
  ,
  output logic [7:0]               bad_op_cnt
`endif
);

  localparam int         AW       = $clog2(DEPTH);
  localparam int         LW       = AW + 1;
  localparam logic [2:0] GAP_LAST = 3'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

  iiu_state_t  r_state;
  logic [LW-1:0] r_len;      // words to issue in this run (clamped to DEPTH)
  logic [LW-1:0] r_cnt;      // words issued so far; low bits address the store
  logic [2:0]    r_gap_cnt;

  logic          w_mem_we;
  logic [31:0]   w_mem_word;
  logic          w_issue_ok;
  logic [31:0]   w_issue_word;
  logic [LW-1:0] w_len;
  logic [LW-1:0] w_cnt_inc;

  // Loads are only honoured while no run is in progress
  assign w_mem_we = load_we && (r_state == S_IDLE);

  iiu_prog_mem #(
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (r_cnt[AW-1:0]),
    .rdata (w_mem_word)
  );

`ifdef IIU_OPCODE_CHECK_EN
  assign w_issue_ok = is_valid_opcode(w_mem_word[OPC_MSB:OPC_LSB]);
`else
  assign w_issue_ok = 1'b1;
`endif

  assign w_issue_word = w_issue_ok ? w_mem_word : NOP_WORD;
  // Clamping the length keeps the address counter inside the store
  assign w_len        = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign w_cnt_inc    = r_cnt + LW'(1);
  assign pc           = r_cnt[AW-1:0];

  // Sequencer FSM with registered outputs; stall freezes all progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_gap_cnt   <= '0;
      instruction <= NOP_WORD;
      issue       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef IIU_OPCODE_CHECK_EN
      bad_op_cnt  <= '0;
`endif
    end else begin
      // Bubble and no pulse unless a branch below says otherwise
      instruction <= NOP_WORD;
      issue       <= 1'b0;
      done        <= 1'b0;
      if (!stall) begin
        case (r_state)
          S_IDLE: begin
            if (start && !load_we) begin
              r_len     <= w_len;
              r_cnt     <= '0;
              r_gap_cnt <= '0;
              if (w_len == '0) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
              end else begin
                r_state <= S_ISSUE;
                busy    <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            instruction <= w_issue_word;
            issue       <= w_issue_ok;
            r_cnt       <= w_cnt_inc;
            r_gap_cnt   <= '0;
`ifdef IIU_OPCODE_CHECK_EN
            if (!w_issue_ok && (bad_op_cnt != 8'hFF)) begin
              bad_op_cnt <= bad_op_cnt + 8'd1;
            end
`endif
            if (ISSUE_GAP > 0) begin
              r_state <= S_GAP;
            end else if (w_cnt_inc == r_len) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
              r_gap_cnt <= '0;
              if (r_cnt < r_len) begin
                r_state <= S_ISSUE;
              end else begin
                r_state <= S_DONE;
                busy    <= 1'b0;
              end
            end else begin
              r_gap_cnt <= r_gap_cnt + 3'd1;
            end
          end
          default: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_issue_unit
// Brief  : Directed self-checking bench for instr_issue_unit (DEPTH=16,
//          ISSUE_GAP=2). Covers reset, spaced issue, stall, zero length,
//          start/load collisions, mid-run reset, length clamp and, with
//          IIU_OPCODE_CHECK_EN, invalid-opcode replacement.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_issue_unit;

  localparam logic [31:0] W0 = 32'h0014_2006;
  localparam logic [31:0] W1 = 32'h0015_08C8;
  localparam logic [31:0] W2 = 32'h0016_054A;
  localparam logic [31:0] WX = 32'h0017_0C4B;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_we = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic [4:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instruction;
  logic        issue;
  logic [3:0]  pc;
  logic        busy;
  logic        done;
`ifdef IIU_OPCODE_CHECK_EN
  logic [7:0]  bad_op_cnt;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Per-run capture
  logic [31:0] got_word [32];
  int          got_cyc  [32];
  logic [3:0]  got_pc   [32];
  int          n_got;
  int          done_at;
  int          nop_bad;
  logic        done_busy;
  logic [3:0]  done_pc;

  instr_issue_unit #(
    .DEPTH     (16),
    .ISSUE_GAP (2),
    .NOP_WORD  (32'h0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .prog_len    (prog_len),
    .start       (start),
    .stall       (stall),
    .instruction (instruction),
    .issue       (issue),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
`ifdef IIU_OPCODE_CHECK_EN
    ,
    .bad_op_cnt  (bad_op_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [3:0] addr, input logic [31:0] data);
    load_we = 1'b1; load_addr = addr; load_data = data;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  // Present start for one edge (edge N); returns #1 after edge N
  task automatic pulse_start(input logic [4:0] len);
    prog_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Observe edges N+1.. ; stall is high for edges N+sf..N+sf+sl-1;
  // bs>0 injects a start at edge N+bs+1 and a load at edge N+bs+2.
  task automatic run_capture(input int budget, input int sf, input int sl, input int bs);
    n_got = 0; done_at = -1; nop_bad = 0; done_busy = 1'bx; done_pc = 'x;
    for (int k = 0; k < 32; k++) begin
      got_word[k] = 32'hDEAD_DEAD; got_cyc[k] = -1; got_pc[k] = 'x;
    end
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #2;
      if (issue) begin
        if (n_got < 32) begin
          got_word[n_got] = instruction; got_cyc[n_got] = c; got_pc[n_got] = pc;
        end
        n_got++;
      end else if (instruction !== 32'h0) begin
        nop_bad++;
      end
      start = 1'b0; load_we = 1'b0;
      if (c == bs) begin
        start = 1'b1; prog_len = 5'd1;
      end
      if (bs > 0 && c == bs + 1) begin
        load_we = 1'b1; load_addr = 4'd2; load_data = 32'hFFFF_FFFF;
      end
      stall = (sl > 0) && (c + 1 >= sf) && (c + 1 < sf + sl);
      if (done) begin
        done_at = c; done_busy = busy; done_pc = pc;
        break;
      end
    end
    stall = 1'b0; start = 1'b0; load_we = 1'b0;
  endtask

  task automatic verify_run(input string tag, input int exp_n, input int exp_done);
    check_eq({tag, "_count"}, n_got, exp_n);
    check_eq({tag, "_done_cycle"}, done_at, exp_done);
    check_eq({tag, "_bubbles_nop"}, nop_bad, 0);
    check_eq({tag, "_busy_at_done"}, {31'b0, done_busy}, 32'd0);
  endtask

  task automatic verify_word(input string tag, input int idx, input logic [31:0] w, input int cyc);
    check_eq({tag, "_word"}, got_word[idx], w);
    check_eq({tag, "_cycle"}, got_cyc[idx], cyc);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_instruction", instruction, 32'h0);
    check_eq("rst_issue", issue, 1'b0);
    check_eq("rst_pc", pc, 4'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
`ifdef IIU_OPCODE_CHECK_EN
    check_eq("rst_bad_op_cnt", bad_op_cnt, 8'd0);
`endif
    @(posedge clk); #1;

    // Three-word program, spurious start/load while busy
    load_word(4'd0, W0);
    load_word(4'd1, W1);
    load_word(4'd2, W2);
    pulse_start(5'd3);
    check_eq("run3_busy_after_start", busy, 1'b1);
    run_capture(40, 0, 0, 2);
    verify_run("run3", 3, 10);
    verify_word("run3_w0", 0, W0, 1);
    verify_word("run3_w1", 1, W1, 4);
    verify_word("run3_w2", 2, W2, 7);
    check_eq("run3_pc_w0", got_pc[0], 4'd1);
    check_eq("run3_pc_w2", got_pc[2], 4'd3);

    // Stall for four edges across the second issue slot
    @(posedge clk); #1;
    pulse_start(5'd3);
    run_capture(40, 4, 4, 0);
    verify_run("stall", 3, 14);
    verify_word("stall_w0", 0, W0, 1);
    verify_word("stall_w1", 1, W1, 8);
    verify_word("stall_w2", 2, W2, 11);

    // Zero-length run
    @(posedge clk); #1;
    pulse_start(5'd0);
    run_capture(10, 0, 0, 0);
    verify_run("len0", 0, 1);

    // start together with load_we: write lands, no run
    @(posedge clk); #1;
    load_we = 1'b1; load_addr = 4'd0; load_data = WX; start = 1'b1; prog_len = 5'd1;
    @(posedge clk); #1;
    load_we = 1'b0; start = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (busy || done || issue) seen++;
    end
    check_eq("start_load_no_run", seen, 0);
    pulse_start(5'd1);
    run_capture(20, 0, 0, 0);
    verify_run("len1", 1, 4);
    verify_word("len1_w", 0, WX, 1);
    load_word(4'd0, W0);

    // Reset while in GAP with a word on the output
    pulse_start(5'd3);
    @(posedge clk); #2;
    check_eq("midrst_pre_issue", issue, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_instruction", instruction, 32'h0);
    check_eq("midrst_issue", issue, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_pc", pc, 4'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start(5'd3);
    run_capture(40, 0, 0, 0);
    verify_run("postrst", 3, 10);
    verify_word("postrst_w1", 1, W1, 4);

`ifdef IIU_OPCODE_CHECK_EN
    // Invalid opcode in slot 1 is replaced by a bubble
    load_word(4'd1, 32'h0000_0011);
    pulse_start(5'd3);
    run_capture(40, 0, 0, 0);
    verify_run("badop", 2, 10);
    verify_word("badop_w0", 0, W0, 1);
    verify_word("badop_w2", 1, W2, 7);
    check_eq("badop_cnt", bad_op_cnt, 8'd1);
    load_word(4'd1, W1);
`endif

    // Length above DEPTH is clamped to DEPTH; pc wraps to 0
    for (int i = 0; i < 16; i++) begin
      load_word(i[3:0], (32'(i) << 16) | 32'd6);
    end
    pulse_start(5'd20);
    run_capture(80, 0, 0, 0);
    verify_run("clamp", 16, 49);
    verify_word("clamp_first", 0, 32'h0000_0006, 1);
    verify_word("clamp_last", 15, 32'h000F_0006, 46);
    check_eq("clamp_pc_wrap", done_pc, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Absolute time guard so the run can never hang
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
